// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: opcodes, functs,
// FSM states and the select codes seen by the datapath muxes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [4:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_ADDR,
        S_MEM_RD,
        S_WB_LOAD,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_LUI,
        S_ILLEGAL
`ifdef MC_OVERFLOW_EXC_EN
        , S_EXC
`endif
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_LUI = 3'd5;

    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_REGA   = 3'd3;
    localparam logic [2:0] PCSRC_EXC    = 3'd4;

    // Destination codes are shared with the register-destination mux downstream.
    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RA = 2'd1;
    localparam logic [1:0] RD_SP = 2'd2;
    localparam logic [1:0] RD_RD = 2'd3;

    localparam logic [1:0] M2R_ALU   = 2'd0;
    localparam logic [1:0] M2R_MDR   = 2'd1;
    localparam logic [1:0] M2R_PC    = 2'd2;
    localparam logic [1:0] M2R_CONST = 2'd3;

    localparam int SP_INIT = 227;

    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_addsub(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the shared
// datapath (slave): instruction fields and ALU flags in, control strobes out.
interface mc_control_fsm_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;

    logic       pc_write;
    logic [2:0] pc_source;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       iord;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dest;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       epc_write;
    logic [4:0] state_dbg;

    modport master (
        input  opcode, funct, zero, overflow,
        output pc_write, pc_source, ir_write, mdr_write, ab_write, alu_out_write,
               iord, mem_write, reg_write, reg_dest, mem_to_reg, alu_src_a,
               alu_src_b, alu_op, epc_write, state_dbg
    );

    modport slave (
        output opcode, funct, zero, overflow,
        input  pc_write, pc_source, ir_write, mdr_write, ab_write, alu_out_write,
               iord, mem_write, reg_write, reg_dest, mem_to_reg, alu_src_a,
               alu_src_b, alu_op, epc_write, state_dbg
    );

endinterface

// File: rtl/mc_wait_counter.sv
// Memory wait-state counter: advances 0..MEM_WAIT while start is high and
// raises done on the final count; clear returns it to zero.
module mc_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic clear,
    output logic done
);

    localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (start && !done) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CW'(MEM_WAIT));

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit: Moore FSM with a Mealy branch pc_write.
// Define MC_OVERFLOW_EXC_EN to add the overflow/illegal-opcode EXC state.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT    = 2,
    parameter int SP_INIT_SEL = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    mc_control_fsm_if.master   bus
);

    state_t state;
    state_t next_state;
    state_t out_state;
    logic   wait_active;
    logic   wait_done;
    logic   ovf_q;

    assign wait_active = (state == S_FETCH) || (state == S_MEM_RD);

    mc_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (wait_active),
        .clear   (wait_active && wait_done),
        .done    (wait_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Overflow is sampled in the execute cycle and consumed at writeback.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (state == S_DECODE) begin
            ovf_q <= 1'b0;
        end else if (state == S_EXEC_R) begin
            ovf_q <= is_addsub(bus.funct) && bus.overflow;
        end else if (state == S_EXEC_I) begin
            ovf_q <= bus.overflow;
        end
    end

`ifndef MC_OVERFLOW_EXC_EN
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_RESET:   next_state = S_FETCH;
            S_FETCH:   next_state = wait_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        case (bus.funct)
                            FN_JR:                                    next_state = S_JR;
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:    next_state = S_EXEC_R;
                            default:                                  next_state = S_ILLEGAL;
                        endcase
                    end
                    OP_ADDI:        next_state = S_EXEC_I;
                    OP_LW, OP_SW:   next_state = S_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    OP_JAL:         next_state = S_JAL;
                    OP_LUI:         next_state = S_LUI;
                    default:        next_state = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:  next_state = S_WB_R;
            S_EXEC_I:  next_state = S_WB_I;
            S_LUI:     next_state = S_WB_I;
            S_ADDR:    next_state = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  next_state = wait_done ? S_WB_LOAD : S_MEM_RD;
`ifdef MC_OVERFLOW_EXC_EN
            S_WB_R:    next_state = ovf_q ? S_EXC : S_FETCH;
            S_WB_I:    next_state = ovf_q ? S_EXC : S_FETCH;
            S_ILLEGAL: next_state = S_EXC;
`endif
            default:   next_state = S_FETCH;
        endcase
    end

    // While reset is held the outputs already perform the $sp init write.
    assign out_state = reset_n ? state : S_RESET;

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_source     = PCSRC_ALU;
        bus.ir_write      = 1'b0;
        bus.mdr_write     = 1'b0;
        bus.ab_write      = 1'b0;
        bus.alu_out_write = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dest      = RD_RT;
        bus.mem_to_reg    = M2R_ALU;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = ALU_ADD;
        bus.epc_write     = 1'b0;
        case (out_state)
            S_RESET: begin
                bus.reg_write  = 1'b1;
                bus.reg_dest   = RD_SP;
                bus.mem_to_reg = 2'(SP_INIT_SEL);
            end
            S_FETCH: begin
                bus.alu_src_b = 2'd1;
                bus.ir_write  = wait_done;
                bus.pc_write  = wait_done;
            end
            S_DECODE: begin
                bus.ab_write      = 1'b1;
                bus.alu_src_b     = 2'd3;
                bus.alu_out_write = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = funct_alu_op(bus.funct);
                bus.alu_out_write = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_src_b     = 2'd2;
                bus.alu_out_write = 1'b1;
            end
            S_WB_R, S_WB_I: begin
`ifdef MC_OVERFLOW_EXC_EN
                bus.reg_write = !ovf_q;
`else
                bus.reg_write = 1'b1;
`endif
                bus.reg_dest  = (out_state == S_WB_R) ? RD_RD : RD_RT;
            end
            S_MEM_RD: begin
                bus.iord      = 1'b1;
                bus.mdr_write = wait_done;
            end
            S_WB_LOAD: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_source = PCSRC_ALUOUT;
                bus.pc_write  = ((bus.opcode == OP_BEQ) && bus.zero) ||
                                ((bus.opcode == OP_BNE) && !bus.zero);
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCSRC_JUMP;
                bus.reg_write  = 1'b1;
                bus.reg_dest   = RD_RA;
                bus.mem_to_reg = M2R_PC;
            end
            S_JR: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_REGA;
            end
            S_LUI: begin
                bus.alu_src_b     = 2'd2;
                bus.alu_op        = ALU_LUI;
                bus.alu_out_write = 1'b1;
            end
`ifdef MC_OVERFLOW_EXC_EN
            S_EXC: begin
                bus.alu_src_b = 2'd1;
                bus.alu_op    = ALU_SUB;
                bus.epc_write = 1'b1;
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_EXC;
            end
`endif
            default: begin
            end
        endcase
    end

    assign bus.state_dbg = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each stimulus cycle queues the expected
// control vector and a negedge monitor pops and compares it.
module tb_mc_control_fsm;

    localparam int MEM_WAIT = 2;

    typedef struct packed {
        logic       pc_write;
        logic [2:0] pc_source;
        logic       ir_write;
        logic       mdr_write;
        logic       ab_write;
        logic       alu_out_write;
        logic       iord;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dest;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       epc_write;
    } ctl_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    ctl_t  exp_q[$];
    string name_q[$];

    mc_control_fsm_if bus_if ();

    mc_control_fsm #(.MEM_WAIT(MEM_WAIT), .SP_INIT_SEL(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t e_reset();
        ctl_t c = '0;
        c.reg_write = 1'b1; c.reg_dest = 2'd2; c.mem_to_reg = 2'd3;
        return c;
    endfunction

    function automatic ctl_t e_fetch(input logic last);
        ctl_t c = '0;
        c.alu_src_b = 2'd1; c.ir_write = last; c.pc_write = last;
        return c;
    endfunction

    function automatic ctl_t e_decode();
        ctl_t c = '0;
        c.ab_write = 1'b1; c.alu_src_b = 2'd3; c.alu_out_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_exec(input logic [1:0] srcb, input logic [2:0] op);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = srcb; c.alu_op = op; c.alu_out_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_wb(input logic rw, input logic [1:0] rd, input logic [1:0] m2r);
        ctl_t c = '0;
        c.reg_write = rw; c.reg_dest = rd; c.mem_to_reg = m2r;
        return c;
    endfunction

    function automatic ctl_t e_mem(input logic rd_last, input logic wr);
        ctl_t c = '0;
        c.iord = 1'b1; c.mdr_write = rd_last; c.mem_write = wr;
        return c;
    endfunction

    function automatic ctl_t e_branch(input logic pcw);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_op = 3'd1; c.pc_source = 3'd1; c.pc_write = pcw;
        return c;
    endfunction

    function automatic ctl_t e_pcjump(input logic [2:0] src, input logic link);
        ctl_t c = '0;
        c.pc_write = 1'b1; c.pc_source = src;
        if (link) begin
            c.reg_write = 1'b1; c.reg_dest = 2'd1; c.mem_to_reg = 2'd2;
        end
        return c;
    endfunction

    function automatic ctl_t e_lui();
        ctl_t c = '0;
        c.alu_src_b = 2'd2; c.alu_op = 3'd5; c.alu_out_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_exc();
        ctl_t c = '0;
        c.alu_src_b = 2'd1; c.alu_op = 3'd1; c.epc_write = 1'b1;
        c.pc_write = 1'b1; c.pc_source = 3'd4;
        return c;
    endfunction

    // Drives one cycle of inputs and queues what the DUT must show during it.
    task automatic applyStimulus(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic ov, input ctl_t e, input string nm);
        reset_n         = rn;
        bus_if.opcode   = op;
        bus_if.funct    = fn;
        bus_if.zero     = z;
        bus_if.overflow = ov;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic runFetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
        for (int k = 0; k <= MEM_WAIT; k++)
            applyStimulus(1'b1, op, fn, 1'b0, 1'b0, e_fetch(k == MEM_WAIT),
                          $sformatf("%s_fetch%0d", tag, k));
    endtask

    task automatic runDecode(input string tag, input logic [5:0] op, input logic [5:0] fn);
        runFetch(tag, op, fn);
        applyStimulus(1'b1, op, fn, 1'b0, 1'b0, e_decode(), {tag, "_decode"});
    endtask

    task automatic checkOutput(input ctl_t exp, input string nm);
        ctl_t got;
        got.pc_write      = bus_if.pc_write;
        got.pc_source     = bus_if.pc_source;
        got.ir_write      = bus_if.ir_write;
        got.mdr_write     = bus_if.mdr_write;
        got.ab_write      = bus_if.ab_write;
        got.alu_out_write = bus_if.alu_out_write;
        got.iord          = bus_if.iord;
        got.mem_write     = bus_if.mem_write;
        got.reg_write     = bus_if.reg_write;
        got.reg_dest      = bus_if.reg_dest;
        got.mem_to_reg    = bus_if.mem_to_reg;
        got.alu_src_a     = bus_if.alu_src_a;
        got.alu_src_b     = bus_if.alu_src_b;
        got.alu_op        = bus_if.alu_op;
        got.epc_write     = bus_if.epc_write;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%b expected=%b", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front(), name_q.pop_front());
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus_if.opcode = 6'h00; bus_if.funct = 6'h00;
        bus_if.zero = 1'b0; bus_if.overflow = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, e_reset(), $sformatf("reset_hold%0d", i));
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, e_reset(), "reset_release");

        runDecode("add", 6'h00, 6'h20);
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, e_exec(2'd0, 3'd0), "add_exec");
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, e_wb(1'b1, 2'd3, 2'd0), "add_wb");

        runDecode("slt", 6'h00, 6'h2A);
        applyStimulus(1'b1, 6'h00, 6'h2A, 1'b0, 1'b0, e_exec(2'd0, 3'd4), "slt_exec");
        applyStimulus(1'b1, 6'h00, 6'h2A, 1'b0, 1'b0, e_wb(1'b1, 2'd3, 2'd0), "slt_wb");

        runDecode("and", 6'h00, 6'h24);
        applyStimulus(1'b1, 6'h00, 6'h24, 1'b0, 1'b0, e_exec(2'd0, 3'd2), "and_exec");
        applyStimulus(1'b1, 6'h00, 6'h24, 1'b0, 1'b0, e_wb(1'b1, 2'd3, 2'd0), "and_wb");

        runDecode("lw", 6'h23, 6'h00);
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, e_exec(2'd2, 3'd0), "lw_addr");
        for (int k = 0; k <= MEM_WAIT; k++)
            applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, e_mem(k == MEM_WAIT, 1'b0),
                          $sformatf("lw_memrd%0d", k));
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, e_wb(1'b1, 2'd0, 2'd1), "lw_wb");

        runDecode("sw", 6'h2B, 6'h00);
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, e_exec(2'd2, 3'd0), "sw_addr");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, e_mem(1'b0, 1'b1), "sw_memwr");

        runDecode("beq_t", 6'h04, 6'h00);
        applyStimulus(1'b1, 6'h04, 6'h00, 1'b1, 1'b0, e_branch(1'b1), "beq_taken");
        runDecode("beq_n", 6'h04, 6'h00);
        applyStimulus(1'b1, 6'h04, 6'h00, 1'b0, 1'b0, e_branch(1'b0), "beq_not");
        runDecode("bne_n", 6'h05, 6'h00);
        applyStimulus(1'b1, 6'h05, 6'h00, 1'b1, 1'b0, e_branch(1'b0), "bne_not");
        runDecode("bne_t", 6'h05, 6'h00);
        applyStimulus(1'b1, 6'h05, 6'h00, 1'b0, 1'b0, e_branch(1'b1), "bne_taken");

        runDecode("j", 6'h02, 6'h00);
        applyStimulus(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, e_pcjump(3'd2, 1'b0), "j_exec");
        runDecode("jal", 6'h03, 6'h00);
        applyStimulus(1'b1, 6'h03, 6'h00, 1'b0, 1'b0, e_pcjump(3'd2, 1'b1), "jal_exec");
        runDecode("jr", 6'h00, 6'h08);
        applyStimulus(1'b1, 6'h00, 6'h08, 1'b0, 1'b0, e_pcjump(3'd3, 1'b0), "jr_exec");

        runDecode("lui", 6'h0F, 6'h00);
        applyStimulus(1'b1, 6'h0F, 6'h00, 1'b0, 1'b0, e_lui(), "lui_exec");
        applyStimulus(1'b1, 6'h0F, 6'h00, 1'b0, 1'b0, e_wb(1'b1, 2'd0, 2'd0), "lui_wb");

        runDecode("addi_ovf", 6'h08, 6'h00);
        applyStimulus(1'b1, 6'h08, 6'h00, 1'b0, 1'b1, e_exec(2'd2, 3'd0), "addi_ovf_exec");
`ifdef MC_OVERFLOW_EXC_EN
        applyStimulus(1'b1, 6'h08, 6'h00, 1'b0, 1'b0, e_wb(1'b0, 2'd0, 2'd0), "addi_ovf_wb");
        applyStimulus(1'b1, 6'h08, 6'h00, 1'b0, 1'b0, e_exc(), "addi_ovf_exc");
`else
        applyStimulus(1'b1, 6'h08, 6'h00, 1'b0, 1'b0, e_wb(1'b1, 2'd0, 2'd0), "addi_ovf_wb");
`endif

        runDecode("sub_ovf", 6'h00, 6'h22);
        applyStimulus(1'b1, 6'h00, 6'h22, 1'b0, 1'b1, e_exec(2'd0, 3'd1), "sub_ovf_exec");
`ifdef MC_OVERFLOW_EXC_EN
        applyStimulus(1'b1, 6'h00, 6'h22, 1'b0, 1'b0, e_wb(1'b0, 2'd3, 2'd0), "sub_ovf_wb");
        applyStimulus(1'b1, 6'h00, 6'h22, 1'b0, 1'b0, e_exc(), "sub_ovf_exc");
`else
        applyStimulus(1'b1, 6'h00, 6'h22, 1'b0, 1'b0, e_wb(1'b1, 2'd3, 2'd0), "sub_ovf_wb");
`endif

        runDecode("illegal", 6'h3F, 6'h00);
        applyStimulus(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, '0, "illegal_nop");
`ifdef MC_OVERFLOW_EXC_EN
        applyStimulus(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, e_exc(), "illegal_exc");
`endif

        runDecode("sw_abort", 6'h2B, 6'h00);
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, e_exec(2'd2, 3'd0), "sw_abort_addr");
        applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, e_reset(), "sw_abort_hold");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, e_reset(), "sw_abort_release");
        runDecode("sw_after", 6'h2B, 6'h00);
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, e_exec(2'd2, 3'd0), "sw_after_addr");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, e_mem(1'b0, 1'b1), "sw_after_memwr");
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, e_fetch(1'b0), "sw_after_next");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS-subset control unit; a Moore FSM with one Mealy output (branch `pc_write`).
- Sits directly upstream of the register-destination mux and drives its 2-bit select: 0=rt, 1=$31, 2=$29, 3=rd.
- Also drives PC, IR, memory, ALU and writeback-mux controls of the shared datapath.
- Inserts memory wait cycles and performs the post-reset $sp initialisation write.

Parameters:
- MEM_WAIT, 2, extra cycles memory needs before read data/write is valid (legal range 0..7).
- SP_INIT_SEL, 3, `mem_to_reg` code that selects the datapath constant 227 for the $29 init write.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed-overflow flag.
- pc_write  out  1  PC load enable.
- pc_source  out  3  0=ALU result, 1=alu_out reg, 2={PC[31:28],IR[25:0],00}, 3=reg A, 4=exception vector.
- ir_write  out  1  IR load.
- mdr_write  out  1  MDR load.
- ab_write  out  1  A/B register load.
- alu_out_write  out  1  ALUOut load.
- iord  out  1  memory address: 0=PC, 1=alu_out.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register bank write enable.
- reg_dest  out  2  destination select, encoding as above.
- mem_to_reg  out  2  0=alu_out, 1=MDR, 2=PC, 3=constant 227.
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT, 5=LUI.
- epc_write  out  1  EPC load; permanently 0 when the optional feature is absent.
- state_dbg  out  5  current state encoding.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `reset_n`.
  - When `reset_n`=0 at a rising edge: state<=RESET, wait counter<=0, ovf_q<=0.
- Defaults: every output is 0 unless a state below says otherwise.
- RESET: `reg_write`=1, `reg_dest`=2, `mem_to_reg`=3.
  - These are also the output values while reset is held, so $29<=227.
  - RESET lasts 1 cycle after release, then goes to FETCH.
- FETCH: `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD, `pc_source`=0.
  - The wait counter counts 0..MEM_WAIT.
  - On the final count only: `ir_write`=1 and `pc_write`=1, counter clears, next state DECODE.
  - FETCH therefore lasts MEM_WAIT+1 cycles.
- DECODE (1 cycle): `ab_write`=1, `alu_src_a`=0, `alu_src_b`=3, `alu_op`=ADD, `alu_out_write`=1.
  - Dispatch on opcode:
    - 0x00: funct 0x08 -> JR; funct 0x20/22/24/25/2A -> EXEC_R.
    - 0x08 -> EXEC_I.
    - 0x23/0x2B -> ADDR.
    - 0x04/0x05 -> BRANCH.
    - 0x02 -> JUMP.
    - 0x03 -> JAL.
    - 0x0F -> LUI.
    - Anything else -> ILLEGAL.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0, `alu_op` from funct (ADD/SUB/AND/OR/SLT), `alu_out_write`=1.
  - Captures ovf_q<=`overflow` for add/sub only.
  - Next state WB_R.
- WB_R: `reg_write`=1, `reg_dest`=3, `mem_to_reg`=0. Next state FETCH.
- EXEC_I: as EXEC_R but `alu_src_b`=2, `alu_op`=ADD. Next state WB_I.
- WB_I: `reg_write`=1, `reg_dest`=0, `mem_to_reg`=0. Next state FETCH.
- ADDR: `alu_src_a`=1, `alu_src_b`=2, ADD, `alu_out_write`=1. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `iord`=1 for MEM_WAIT+1 cycles; `mdr_write`=1 on the final cycle. Next state WB_LOAD.
- WB_LOAD: `reg_write`=1, `reg_dest`=0, `mem_to_reg`=1. Next state FETCH.
- MEM_WR: `iord`=1; `mem_write`=1 for exactly 1 cycle. Next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_source`=1.
  - `pc_write`=(beq&`zero`)|(bne&!`zero`), combinational.
  - Next state FETCH.
- JUMP: `pc_write`=1, `pc_source`=2.
- JAL: `pc_write`=1, `pc_source`=2, `reg_write`=1, `reg_dest`=1, `mem_to_reg`=2.
  - The PC value written to $31 is the already-incremented PC.
- JR: `pc_write`=1, `pc_source`=3.
- LUI: `alu_src_b`=2, `alu_op`=LUI, `alu_out_write`=1. Next state WB_I.
- ILLEGAL: 1 cycle, no side effects, next state FETCH (acts as a NOP).
- Latency with MEM_WAIT=2:
  - R-type 6 cycles; addi/lui 6; lw 9; sw 6; beq/bne/j/jal/jr 5.
- Reset mid-instruction: abandoned at the next edge; no `mem_write` or `reg_write` from the aborted instruction appears after reset is released.
- Overflow without the optional feature is ignored; writeback proceeds.

Optional Feature:
- MC_OVERFLOW_EXC_EN defined:
  - In WB_R/WB_I, if ovf_q=1, `reg_write` is suppressed and the next state is EXC.
  - ILLEGAL also goes to EXC.
  - EXC (1 cycle): `alu_src_a`=0, `alu_src_b`=1, `alu_op`=SUB, `epc_write`=1 (EPC<=PC-4), `pc_write`=1, `pc_source`=4. Next state FETCH.
- MC_OVERFLOW_EXC_EN undefined:
  - No EXC state exists; `epc_write` is tied to 0; ovf_q is unused.

Decomposition:
- Shared package `mc_ctrl_pkg`, holding:
  - opcode and funct constants;
  - the state enum;
  - `alu_op`, `pc_source`, `reg_dest` and `mem_to_reg` encodings (reg_dest codes shared with the destination mux);
  - SP_INIT value 227.
- One sub-module, `mc_wait_counter`: a MEM_WAIT-parameterised counter with start, clear and done.
  - Used by FETCH and MEM_RD.

Test Plan:
- Hold `reset_n`=0 for 3 cycles, then release -> every held cycle and the first cycle after release show `reg_write`=1, `reg_dest`=2, `mem_to_reg`=3; then FETCH, with `ir_write`/`pc_write` high only on the 3rd FETCH cycle.
- opcode 0, funct 0x20 -> DECODE, EXEC_R (`alu_op`=0), WB_R with `reg_dest`=3, `reg_write`=1; total 6 cycles.
- opcode 0x23 (lw) -> `mdr_write` on the 3rd MEM_RD cycle, then WB_LOAD with `reg_dest`=0, `mem_to_reg`=1; 9 cycles. opcode 0x2B (sw) -> `mem_write` high exactly 1 cycle.
- opcode 0x04 with `zero`=1 -> `pc_write`=1, `pc_source`=1; with `zero`=0 -> `pc_write`=0. opcode 0x05 gives the inverse.
- opcode 0x03 (jal) -> `reg_dest`=1, `mem_to_reg`=2, `pc_source`=2, `reg_write`=`pc_write`=1 in the same cycle.
- With MC_OVERFLOW_EXC_EN defined: addi with `overflow`=1 -> no `reg_write`; EXC asserts `epc_write`=1, `pc_source`=4. Without the macro: `reg_write`=1 and `epc_write` stays 0. Assert `reset_n`=0 during MEM_WR -> no `mem_write` after release.
